// File: rtl/vga_pkg.sv
// vga_pkg: shared pixel types, screen size defaults and the box colour palette
package vga_pkg;
  typedef logic [11:0] rgb12_t;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam rgb12_t PALETTE [8] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F,
                                     12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF};
endpackage

// File: rtl/bounce_axis.sv
// bounce_axis: one axis of box motion, reflecting off 0 and LIM-BOX_SIZE
module bounce_axis #(
  parameter int LIM = 640,
  parameter int BOX_SIZE = 32,
  parameter int SPEED = 2,
  parameter int P0 = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [9:0] pos,
  output logic       hit
);
  logic       dir;
  logic [10:0] fwd;
  logic       at_wall;
  // wall test in 11 bits so the far edge plus the step never wraps
  always_comb begin
    fwd = {1'b0, pos} + 11'(BOX_SIZE + SPEED);
    at_wall = dir ? (fwd > 11'(LIM)) : (pos < 10'(SPEED));
    hit = step && at_wall;
  end
  // position/direction advance once per step; a wall hit clamps and reverses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pos <= 10'(P0);
      dir <= 1'b1;
    end else if (step) begin
      pos <= at_wall ? (dir ? 10'(LIM - BOX_SIZE) : 10'd0) : (dir ? pos + 10'(SPEED) : pos - 10'(SPEED));
      dir <= at_wall ? ~dir : dir;
    end
endmodule

// File: rtl/vga_bounce_box.sv
// vga_bounce_box: bouncing solid square pixel source with one-strobe output pipeline
module vga_bounce_box #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int BOX_SIZE = 32,
  parameter int SPEED = 2,
  parameter int X0 = 100,
  parameter int Y0 = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       move_en,
  input  logic       frame_tick,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic       de,
  input  logic       hs,
  input  logic       vs,
  output logic [3:0] r_o,
  output logic [3:0] g_o,
  output logic [3:0] b_o,
  output logic       de_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic       corner_o
);
  import vga_pkg::*;
  logic       step, hit_x, hit_y, in_box;
  logic [9:0] x, y;
  logic [2:0] cidx;
  assign step = pix_en & frame_tick & move_en;
  bounce_axis #(.LIM(H_ACTIVE), .BOX_SIZE(BOX_SIZE), .SPEED(SPEED), .P0(X0)) u_x (
    .clk(clk), .rst(rst), .step(step), .pos(x), .hit(hit_x));
  bounce_axis #(.LIM(V_ACTIVE), .BOX_SIZE(BOX_SIZE), .SPEED(SPEED), .P0(Y0)) u_y (
    .clk(clk), .rst(rst), .step(step), .pos(y), .hit(hit_y));
  // box hit test against the current (pre-update) position
  always_comb
    in_box = de && (px >= x) && ({1'b0, px} < {1'b0, x} + 11'(BOX_SIZE))
                && (py >= y) && ({1'b0, py} < {1'b0, y} + 11'(BOX_SIZE));
  // output pipeline and palette index, both advancing only on the pixel strobe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {r_o, g_o, b_o} <= '0;
      de_o <= 1'b0;
      hs_o <= 1'b1;
      vs_o <= 1'b1;
      corner_o <= 1'b0;
      cidx <= 3'd1;
    end else if (pix_en) begin
      {r_o, g_o, b_o} <= in_box ? PALETTE[cidx] : 12'h000;
      de_o <= de;
      hs_o <= hs;
      vs_o <= vs;
      corner_o <= hit_x & hit_y;
      cidx <= cidx + 3'(hit_x | hit_y);
    end
endmodule
